// File: rtl/render_pkg.sv
// Shared types and helpers for the VGA render pipeline.
package render_pkg;

  localparam int unsigned RGB_W   = 12;
  localparam int unsigned LVL_MAX = 16;

  typedef enum logic [1:0] {IDLE, FADE_OUT, BLACK, FADE_IN} fade_state_e;

  // Scale each 4-bit channel by level/16; level 16 is identity, level 0 is black.
  function automatic logic [RGB_W-1:0] rgb_scale(input logic [RGB_W-1:0] rgb,
                                                 input logic [4:0]       level);
    logic [8:0]       prod;
    logic [RGB_W-1:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      prod = {5'd0, rgb[ch*4 +: 4]} * {4'd0, level};
      res[ch*4 +: 4] = 4'(prod >> 4);
    end
    return res;
  endfunction

endpackage

// File: rtl/layer_compositor_fade_ctrl.sv
// Frame-synchronous fade-out / hold-black / fade-in sequencer.
module fade_ctrl
  import render_pkg::*;
#(
  parameter int unsigned FADE_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       fade_req,
  output logic [4:0] fade_level,
  output logic       fade_busy,
  output logic       black_pulse
);

  localparam int unsigned CNT_MAX = (FADE_FRAMES > HOLD_FRAMES) ? FADE_FRAMES : HOLD_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FADE_LAST = CNT_W'(FADE_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [4:0]       LVL_FULL  = 5'(LVL_MAX);

  fade_state_e      state_q;
  logic [CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      fade_level  <= LVL_FULL;
      fade_busy   <= 1'b0;
      black_pulse <= 1'b0;
    end else begin
      black_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          // A frame_start in the same cycle is deliberately not counted.
          if (fade_req) begin
            state_q     <= FADE_OUT;
            frame_cnt_q <= '0;
            fade_busy   <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_start) begin
            if (frame_cnt_q == FADE_LAST) begin
              frame_cnt_q <= '0;
              fade_level  <= fade_level - 5'd1;
              if (fade_level == 5'd1) begin
                state_q     <= BLACK;
                black_pulse <= 1'b1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
          end
        end
        BLACK: begin
          if (frame_start) begin
            if (frame_cnt_q == HOLD_LAST) begin
              frame_cnt_q <= '0;
              state_q     <= FADE_IN;
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
          end
        end
        FADE_IN: begin
          if (frame_start) begin
            if (frame_cnt_q == FADE_LAST) begin
              frame_cnt_q <= '0;
              fade_level  <= fade_level + 5'd1;
              if (fade_level == LVL_FULL - 5'd1) begin
                state_q   <= IDLE;
                fade_busy <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority compositor with frame-synchronous fade and probe-layer overlap tracking.
module layer_compositor
  import render_pkg::*;
#(
  parameter int unsigned       NUM_LAYERS  = 8,
  parameter int unsigned       PROBE_LAYER = 0,
  parameter int unsigned       FADE_FRAMES = 2,
  parameter int unsigned       HOLD_FRAMES = 30,
  parameter logic [RGB_W-1:0]  KEY_RGB     = 12'h0F0,
  localparam int unsigned      TOP_W       = $clog2(NUM_LAYERS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [RGB_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic                        fade_req,
  output logic [RGB_W-1:0]            rgb_out,
  output logic                        rgb_valid,
  output logic [TOP_W-1:0]            top_layer,
  output logic [4:0]                  fade_level,
  output logic                        fade_busy,
  output logic                        black_pulse,
  output logic [NUM_LAYERS-1:0]       overlap_flags
);

  logic [NUM_LAYERS-1:0]       opaque;
  logic [NUM_LAYERS-1:0]       s1_opaque_q;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb_q;
  logic [RGB_W-1:0]            s1_bg_q;
  logic                        s1_valid_q;
  logic [RGB_W-1:0]            sel_rgb;
  logic [TOP_W-1:0]            sel_top;
  logic [RGB_W-1:0]            s2_rgb_q;
  logic [TOP_W-1:0]            s2_top_q;
  logic                        s2_valid_q;
  logic [4:0]                  lvl_q;
  logic [NUM_LAYERS-1:0]       hit_vec;
  logic [NUM_LAYERS-1:0]       acc_q;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = layer_hit[i] & layer_en[i] & (layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB);
    end
  end

  // Later (higher-index) opaque layers overwrite earlier ones.
  always_comb begin
    sel_rgb = s1_bg_q;
    sel_top = TOP_W'(NUM_LAYERS);
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_opaque_q[i]) begin
        sel_rgb = s1_rgb_q[i*RGB_W +: RGB_W];
        sel_top = TOP_W'(i);
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    if (s1_valid_q && s1_opaque_q[PROBE_LAYER]) begin
      hit_vec              = s1_opaque_q;
      hit_vec[PROBE_LAYER] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_opaque_q   <= '0;
      s1_rgb_q      <= '0;
      s1_bg_q       <= '0;
      s1_valid_q    <= 1'b0;
      s2_rgb_q      <= '0;
      s2_top_q      <= '0;
      s2_valid_q    <= 1'b0;
      lvl_q         <= 5'(LVL_MAX);
      rgb_out       <= '0;
      rgb_valid     <= 1'b0;
      top_layer     <= TOP_W'(NUM_LAYERS);
      acc_q         <= '0;
      overlap_flags <= '0;
    end else begin
      s1_opaque_q <= opaque;
      s1_rgb_q    <= layer_rgb;
      s1_bg_q     <= bg_rgb;
      s1_valid_q  <= pix_valid;
      s2_rgb_q    <= sel_rgb;
      s2_top_q    <= sel_top;
      s2_valid_q  <= pix_valid ? s1_valid_q : s1_valid_q;
      // Level only changes at frame boundaries so no frame mixes two brightnesses.
      if (frame_start) lvl_q <= fade_level;
      rgb_out   <= s2_valid_q ? rgb_scale(s2_rgb_q, lvl_q) : '0;
      rgb_valid <= s2_valid_q;
      top_layer <= s2_top_q;
      if (frame_start) begin
        overlap_flags <= acc_q;
        acc_q         <= hit_vec;
      end else begin
        acc_q <= acc_q | hit_vec;
      end
    end
  end

  fade_ctrl #(
    .FADE_FRAMES (FADE_FRAMES),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_fade_ctrl (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .fade_req    (fade_req),
    .fade_level  (fade_level),
    .fade_busy   (fade_busy),
    .black_pulse (black_pulse)
  );

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised scoreboard bench for layer_compositor against a frame-level reference model.
module tb_layer_compositor;

  localparam int N  = 8;
  localparam int TW = $clog2(N) + 1;
  localparam int F  = 2;
  localparam int H  = 3;
  localparam int P  = 0;
  localparam logic [11:0] KEY = 12'h0F0;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start, pix_valid, fade_req;
  logic [11:0]   bg_rgb;
  logic [N-1:0]  layer_hit, layer_en;
  logic [N*12-1:0] layer_rgb;
  logic [11:0]   rgb_out;
  logic          rgb_valid, fade_busy, black_pulse;
  logic [TW-1:0] top_layer;
  logic [4:0]    fade_level;
  logic [N-1:0]  overlap_flags;

  always #5 clk = ~clk;

  layer_compositor #(
    .NUM_LAYERS  (N),
    .PROBE_LAYER (P),
    .FADE_FRAMES (F),
    .HOLD_FRAMES (H),
    .KEY_RGB     (KEY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .bg_rgb        (bg_rgb),
    .layer_hit     (layer_hit),
    .layer_rgb     (layer_rgb),
    .layer_en      (layer_en),
    .fade_req      (fade_req),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid),
    .top_layer     (top_layer),
    .fade_level    (fade_level),
    .fade_busy     (fade_busy),
    .black_pulse   (black_pulse),
    .overlap_flags (overlap_flags)
  );

  typedef struct {
    int            stamp;
    logic [11:0]   rgb;
    logic          v;
    logic [TW-1:0] top;
  } pix_t;

  typedef struct {
    int           stamp;
    logic [4:0]   lvl;
    logic         busy;
    logic         pulse;
    logic [N-1:0] flags;
  } ctl_t;

  pix_t pq[$];
  ctl_t cq[$];
  pix_t me;
  ctl_t mc;

  int checks = 0, errors = 0, cyc = 0, pulse_seen = 0, pulse_exp = 0;

  // Reference model state: fade progress is "frames counted since fade_req".
  bit           m_active = 0;
  int           m_k = 0;
  int           slvl = 16;
  logic [N-1:0] m_acc = '0, m_flags = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int model_level(input bit act, input int kk);
    if (!act) return 16;
    if (kk <= 16*F) return 16 - kk/F;
    if (kk <= 16*F + H) return 0;
    if ((kk - 16*F - H)/F > 16) return 16;
    return (kk - 16*F - H)/F;
  endfunction

  function automatic int scale(input int c, input int lvl);
    return ((((c >> 8) & 15) * lvl / 16) << 8) | ((((c >> 4) & 15) * lvl / 16) << 4)
           | ((c & 15) * lvl / 16);
  endfunction

  task automatic drive(input bit fs, input bit pv, input logic [11:0] bg, input logic [N-1:0] hit,
                       input logic [N*12-1:0] rgbs, input logic [N-1:0] en, input bit freq);
    logic [N-1:0] opq;
    logic [N-1:0] others;
    logic [11:0]  col;
    int           win;
    bit           was, pulse;
    pix_t         p;
    ctl_t         c;
    @(posedge clk);
    #1;
    frame_start = fs; pix_valid = pv; bg_rgb = bg; layer_hit = hit;
    layer_rgb = rgbs; layer_en = en; fade_req = freq;
    for (int i = 0; i < N; i++) begin
      col    = rgbs[i*12 +: 12];
      opq[i] = hit[i] && en[i] && (col != KEY);
    end
    was   = m_active;
    pulse = 0;
    if (fs) slvl = model_level(m_active, m_k);
    if (fs && was) begin
      m_k++;
      if (m_k == 16*F) begin
        pulse = 1;
        pulse_exp++;
      end
      if (m_k >= 32*F + H) m_active = 0;
    end
    if (freq && !was) begin
      m_active = 1;
      m_k      = 0;
    end
    if (fs) begin
      m_flags = m_acc;
      m_acc   = '0;
    end
    if (pv && opq[P]) begin
      others    = opq;
      others[P] = 1'b0;
      m_acc     = m_acc | others;
    end
    if (fs || freq) begin
      c.stamp = cyc;
      c.lvl   = 5'(model_level(m_active, m_k));
      c.busy  = m_active;
      c.pulse = pulse;
      c.flags = m_flags;
      cq.push_back(c);
    end
    win = N;
    for (int i = 0; i < N; i++) if (opq[i]) win = i;
    p.stamp = cyc;
    p.v     = pv;
    p.top   = TW'(win);
    if (!pv)           p.rgb = '0;
    else if (win == N) p.rgb = 12'(scale(int'(bg), slvl));
    else               p.rgb = 12'(scale(int'(rgbs[win*12 +: 12]), slvl));
    pq.push_back(p);
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, '0, 0);
  endtask

  task automatic rand_pix(input bit fs, input bit freq);
    logic [N*12-1:0] r;
    int              sel;
    for (int i = 0; i < N; i++) begin
      sel = int'($urandom % 4);
      r[i*12 +: 12] = (sel == 0) ? KEY : (sel == 1) ? 12'hFFF : 12'($urandom);
    end
    drive(fs, ($urandom % 8) != 0, 12'($urandom), N'($urandom), r,
          N'($urandom | $urandom), freq);
  endtask

  // Probe layer 0 and layer 3 both opaque on a visible pixel.
  task automatic ovl_pix(input bit fs, input bit freq);
    drive(fs, 1, 12'h000, N'(8'h09), {N{12'h321}}, '1, freq);
  endtask

  // Trailing blank cycles keep every pixel of a frame on that frame's level.
  task automatic frame(input int npix, input bit fs_ovl, input bit mid_ovl,
                       input bit freq_fs, input bit freq_mid);
    if (fs_ovl)        ovl_pix(1, freq_fs);
    else if (npix > 0) rand_pix(1, freq_fs);
    else               drive(1, 0, '0, '0, '0, '0, freq_fs);
    if (mid_ovl) ovl_pix(0, 0);
    for (int i = 0; i < npix; i++) rand_pix(0, freq_mid && (i == 0));
    repeat (3) idle();
  endtask

  task automatic drain();
    int b = 0;
    while ((pq.size() != 0 || cq.size() != 0) && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (pq.size() + cq.size() != 0) chk("drain_timeout", pq.size() + cq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (black_pulse) pulse_seen++;
    while (pq.size() > 0 && pq[0].stamp + 3 <= cyc) begin
      me = pq.pop_front();
      if (me.stamp + 3 != cyc) chk("pix_late", cyc, me.stamp + 3);
      else begin
        chk("rgb_out", rgb_out, me.rgb);
        chk("rgb_valid", rgb_valid, me.v);
        chk("top_layer", top_layer, me.top);
      end
    end
    while (cq.size() > 0 && cq[0].stamp + 1 <= cyc) begin
      mc = cq.pop_front();
      if (mc.stamp + 1 != cyc) chk("ctl_late", cyc, mc.stamp + 1);
      else begin
        chk("fade_level", fade_level, mc.lvl);
        chk("fade_busy", fade_busy, mc.busy);
        chk("black_pulse", black_pulse, mc.pulse);
        chk("overlap_flags", overlap_flags, mc.flags);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*12-1:0] d;
    int fr;
    rst = 1; frame_start = 0; pix_valid = 0; fade_req = 0;
    bg_rgb = '0; layer_hit = '0; layer_en = '0; layer_rgb = '0;
    #3;
    chk("rst_rgb_out", rgb_out, 0);
    chk("rst_rgb_valid", rgb_valid, 0);
    chk("rst_top_layer", top_layer, N);
    chk("rst_fade_level", fade_level, 16);
    chk("rst_fade_busy", fade_busy, 0);
    chk("rst_black_pulse", black_pulse, 0);
    chk("rst_overlap_flags", overlap_flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Directed priority, enable, colour key, background and blanking cases.
    d = '0;
    d[2*12 +: 12] = 12'h123;
    d[5*12 +: 12] = 12'h456;
    drive(0, 1, 12'hABC, N'(8'h24), d, N'(8'hFF), 0);
    drive(0, 1, 12'hABC, N'(8'h24), d, N'(8'hDF), 0);
    d[5*12 +: 12] = KEY;
    drive(0, 1, 12'hABC, N'(8'h24), d, N'(8'hFF), 0);
    drive(0, 1, 12'hABC, '0, d, N'(8'hFF), 0);
    drive(0, 0, 12'hABC, N'(8'h24), d, N'(8'hFF), 0);
    repeat (3) idle();

    // Overlap reporting, including a hit on the frame_start cycle.
    frame(0, 0, 1, 0, 0);
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    frame(0, 1, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    repeat (3) frame(4, 0, 0, 0, 0);

    // Full fade, started with fade_req on a frame_start; a second request mid fade-out.
    frame(4, 0, 0, 1, 0);
    fr = 0;
    while (m_active && fr < 100) begin
      frame(4, 0, 0, 0, fr == 4);
      fr++;
    end
    repeat (2) frame(4, 0, 0, 0, 0);

    // Second fade, interrupted by reset at level 5.
    frame(2, 0, 0, 0, 1);
    fr = 0;
    while (model_level(m_active, m_k) != 5 && fr < 60) begin
      frame(2, 0, 0, 0, 0);
      fr++;
    end
    drain();
    #2;
    rst = 1;
    #1;
    chk("midrst_fade_level", fade_level, 16);
    chk("midrst_fade_busy", fade_busy, 0);
    chk("midrst_black_pulse", black_pulse, 0);
    chk("midrst_rgb_valid", rgb_valid, 0);
    chk("midrst_overlap_flags", overlap_flags, 0);
    m_active = 0; m_k = 0; slvl = 16; m_acc = '0; m_flags = '0;
    @(negedge clk);
    rst = 0;

    repeat (3) frame(4, 0, 0, 0, 0);
    drain();
    chk("black_pulse_count", pulse_seen, pulse_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer pixel compositor for the VGA pipeline; the next generation of the fixed cloud/apple/bullet/kid priority mux.
- Selects the highest-priority enabled opaque layer per pixel and applies a frame-synchronous fade-to-black/fade-in effect driven by an FSM.
- Accumulates per-frame overlap flags between a probe layer (the kid) and all other layers, for hit detection.
- Sits between the sprite modules and the VGA output register.

Parameters:
- NUM_LAYERS, 8, number of sprite layers; index NUM_LAYERS-1 has highest priority.
- PROBE_LAYER, 0, layer whose overlap with the other layers is tracked.
- FADE_FRAMES, 2, frames per fade level step (>=1).
- HOLD_FRAMES, 30, frames held fully black before fade-in (>=1).
- KEY_RGB, 12'h0F0, colour key; a layer pixel equal to it is transparent.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse at pixel (0,0) of each frame
- pix_valid  in  1  current col/row is inside the visible area
- bg_rgb  in  12  background (scene) colour
- layer_hit  in  NUM_LAYERS  per-layer coverage of the current pixel
- layer_rgb  in  NUM_LAYERS*12  per-layer colour; layer i occupies [i*12+11 -: 12]
- layer_en  in  NUM_LAYERS  per-layer enable mask
- fade_req  in  1  pulse: start fade-out sequence
- rgb_out  out  12  composited, faded colour
- rgb_valid  out  1  pix_valid delayed to align with rgb_out
- top_layer  out  clog2(NUM_LAYERS)+1  winning layer index; NUM_LAYERS means background
- fade_level  out  5  current brightness, 0..16
- fade_busy  out  1  FSM not in IDLE
- black_pulse  out  1  one-cycle pulse on entry to BLACK (used as game reset)
- overlap_flags  out  NUM_LAYERS  previous frame's probe overlaps; the PROBE_LAYER bit is always 0

Behaviour:
- Reset: asynchronous and active-high; clk and rst as named above.
- Reset values: rgb_out=0, rgb_valid=0, top_layer=NUM_LAYERS, fade_level=16, fade_busy=0, black_pulse=0, overlap_flags=0, FSM=IDLE, all pipeline registers 0.
- Layer qualification: layer i is opaque iff layer_hit[i] & layer_en[i] & (layer_rgb[i] != KEY_RGB).
- Pipeline, latency 3 clk from inputs to rgb_out/rgb_valid/top_layer:
  - S1 registers the qualified mask, colours, bg_rgb and pix_valid.
  - S2 performs the priority select: highest opaque index wins, else bg_rgb with top_layer=NUM_LAYERS.
  - S3 applies fade: each 4-bit channel = (c*fade_level)>>4, with a 9-bit intermediate; level 16 is identity and level 0 is black.
- Blanking: when the S3 pix_valid is 0, rgb_out=0 regardless of layers.
- Fade level sampling: fade_level is sampled into S3 only at frame_start, so a frame never mixes two levels.
- FSM states: IDLE, FADE_OUT, BLACK, FADE_IN. A frame counter counts frame_start pulses.
  - IDLE: level 16. fade_req -> FADE_OUT, frame counter cleared.
  - FADE_OUT: level decrements by 1 on every FADE_FRAMES-th frame_start. At level 0 -> BLACK; black_pulse asserted in the transition cycle.
  - BLACK: after HOLD_FRAMES frame_starts -> FADE_IN.
  - FADE_IN: level increments by 1 every FADE_FRAMES frame_starts. At level 16 -> IDLE.
- fade_req is ignored outside IDLE.
- fade_req coinciding with frame_start in IDLE: enters FADE_OUT, and that frame_start does not count.
- Overlap accumulator:
  - Sticky bit j sets when S1 opaque[PROBE_LAYER] & opaque[j] & pix_valid, for j != PROBE_LAYER.
  - On frame_start the accumulator is copied to overlap_flags and cleared.
  - A hit in the same cycle as frame_start goes to the new frame.
- rst mid-fade: immediately returns to IDLE, level 16, no black_pulse.

Decomposition:
- Shared package (render_pkg):
  - RGB_W=12, LVL_MAX=16
  - fade state enum {IDLE, FADE_OUT, BLACK, FADE_IN}
  - function rgb_scale(rgb, level)
- One sub-module: fade_ctrl (FSM, frame counter, fade_level, black_pulse, fade_busy).
- The priority select and overlap accumulator stay in layer_compositor.

Test Plan:
- NUM_LAYERS=8; layers 2 and 5 hit, enabled, colours 12'h123/12'h456 -> 3 clk later rgb_out=12'h456, top_layer=5. Disable layer 5 -> 12'h123, top_layer=2.
- Layer 5 colour = KEY_RGB -> transparent, output 12'h123. No layers hit -> bg_rgb=12'hABC out, top_layer=8. pix_valid=0 -> rgb_out=0, rgb_valid=0.
- FADE_FRAMES=2, HOLD_FRAMES=3; pulse fade_req, drive frame_starts:
  - level 16->0 over 32 frames, then black_pulse once, then 3 frames at 0, then ramp back to 16 over 32 frames, then IDLE with fade_busy=0.
  - Mid-sequence at level 8, layer colour 12'hFFF -> rgb_out=12'h777.
- Second fade_req during FADE_OUT -> no effect on the level sequence. Assert rst at level 5 -> fade_level=16 and IDLE immediately (async), no black_pulse.
- Probe layer 0 overlaps layer 3 on one pixel in frame N -> overlap_flags=8'h08 after frame N+1's frame_start. No overlap in frame N+1 -> 8'h00 after the next frame_start.
- Overlap coinciding with frame_start -> reported one frame later, not in the current copy.
